wave_scope: RTL and testbench

WAVE_SCOPE -- requirements
Module: wave_scope

---
 rtl/wave_pkg.sv | 29 ++
 rtl/wave_pixel.sv | 54 +++++
 rtl/wave_scope.sv | 92 +++++++++
 tb/tb_wave_scope.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types and constants for the wave_scope OLED oscilloscope.
package wave_pkg;
    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } scope_st_t;

    localparam logic [15:0] CLR_LOW   = 16'h867F;
    localparam logic [15:0] CLR_MID   = 16'hFD8F;
    localparam logic [15:0] CLR_HIGH  = 16'hF81F;
    localparam logic [15:0] CLR_WHITE = 16'hFFFF;
    localparam logic [15:0] CLR_BLACK = 16'h0000;
    localparam logic [15:0] CLR_GRID  = 16'h2104;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Bands split at exactly one and two thirds of the display height.
    function automatic logic [15:0] band_colour(input int m, input int rows);
        if (3 * m < rows)     return CLR_LOW;
        if (3 * m < 2 * rows) return CLR_MID;
        return CLR_HIGH;
    endfunction
endpackage

// File: rtl/wave_pixel.sv
// Maps (x, y) and the captured column heights to a registered RGB565 pixel.
// Optional background grid enabled by defining WAVE_SCOPE_GRID_EN.
module wave_pixel
    import wave_pkg::*;
#(
    parameter int COLS = OLED_W,
    parameter int ROWS = OLED_H,
    parameter int HB   = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [6:0]               x,
    input  logic [6:0]               y,
    input  logic [COLS-1:0][HB-1:0]  heights,
    output logic [15:0]              oled_data
);
    localparam int MID = ROWS / 2;

    logic        in_rng, lit, base;
    int          h, ym, m;
    logic [15:0] pix;

    always_comb begin
        in_rng = (int'(x) < COLS) && (int'(y) < ROWS);
        h      = in_rng ? int'(heights[x]) : 0;
        ym     = ROWS - 1 - int'(y);
        if (!mode) begin
            lit  = ym < h;
            m    = h;
            base = (h == 0) && (ym == 0);
        end else begin
            lit  = iabs(ym - MID) < iabs(h - MID);
            m    = 2 * iabs(h - MID);
            base = (h == MID) && (ym == MID);
        end
        pix = CLR_BLACK;
        if (in_rng) begin
            if (lit)
                pix = band_colour(m, ROWS);
            else if (base)
                pix = CLR_WHITE;
`ifdef WAVE_SCOPE_GRID_EN
            else if (x[3:0] == 4'd0 || y[3:0] == 4'd0)
                pix = CLR_GRID;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) oled_data <= '0;
        else     oled_data <= pix;
    end
endmodule

// File: rtl/wave_scope.sv
// Triggered single-sweep sample capture (ARM/FILL/HOLD) feeding the pixel mapper.
module wave_scope
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int COLS     = OLED_W,
    parameter int ROWS     = OLED_H,
    parameter int DECIM    = 1,
    parameter int AUTO_TO  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                freeze,
    input  logic                mode,
    input  logic [6:0]          x,
    input  logic [6:0]          y,
    output logic [15:0]         oled_data,
    output logic                triggered
);
    localparam int HB = $clog2(ROWS);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW = (AUTO_TO > 0) ? $clog2(AUTO_TO + 1) : 1;
    localparam int IW = $clog2(COLS);

    scope_st_t               state;
    logic [DW-1:0]           dcnt;
    logic [TW-1:0]           tcnt;
    logic [IW-1:0]           wr_idx;
    logic [SAMPLE_W-1:0]     prev;
    // Only the displayed height bits of each sample are retained.
    logic [COLS-1:0][HB-1:0] hgt_buf;

    logic          kept, trig_ev;
    logic [HB-1:0] hnew;

    assign kept    = sample_valid && (dcnt == '0);
    assign trig_ev = kept && (prev < trig_level) && (sample >= trig_level);
    assign hnew    = sample[SAMPLE_W-1 -: HB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ARM;
            dcnt      <= '0;
            tcnt      <= '0;
            wr_idx    <= '0;
            prev      <= '0;
            hgt_buf   <= '0;
            triggered <= 1'b0;
        end else if (!freeze) begin
            if (sample_valid)
                dcnt <= (dcnt == DW'(DECIM - 1)) ? '0 : dcnt + 1'b1;
            if (kept)
                prev <= sample;
            case (state)
                ST_ARM: if (kept) begin
                    if (trig_ev || tcnt == TW'(AUTO_TO)) begin
                        hgt_buf[0] <= hnew;
                        wr_idx     <= IW'(1);
                        tcnt       <= '0;
                        state      <= ST_FILL;
                        triggered  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_FILL: if (kept) begin
                    hgt_buf[wr_idx] <= hnew;
                    if (wr_idx == IW'(COLS - 1)) state  <= ST_HOLD;
                    else                         wr_idx <= wr_idx + 1'b1;
                end
                ST_HOLD: begin
                    state     <= ST_ARM;
                    triggered <= 1'b0;
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    wave_pixel #(.COLS(COLS), .ROWS(ROWS), .HB(HB)) u_pix (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .x         (x),
        .y         (y),
        .heights   (hgt_buf),
        .oled_data (oled_data)
    );
endmodule

// File: tb/tb_wave_scope.sv
// Randomized bench for wave_scope: two instances (DECIM 1 and 4) against a sample-level model.
module tb_wave_scope;
    localparam int NC = 96, NR = 64, AUTO = 255;

    logic        clk = 1'b0, rst = 1'b0, sample_valid = 1'b0, freeze = 1'b0, mode = 1'b0;
    logic [11:0] sample = '0, trig_level = '0;
    logic [6:0]  x = '0, y = '0;
    logic [15:0] od1, od4;
    logic        trg1, trg4;

    int errors = 0, checks = 0;

    // model: 0 = armed, 1 = capturing, 2 = holding
    int st[2], pulses[2], prv[2], tmo[2], idx[2];
    int mb[2][NC];

    wave_scope #(.DECIM(1)) dut1 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .trig_level(trig_level), .freeze(freeze), .mode(mode), .x(x), .y(y),
        .oled_data(od1), .triggered(trg1));

    wave_scope #(.DECIM(4)) dut4 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .trig_level(trig_level), .freeze(freeze), .mode(mode), .x(x), .y(y),
        .oled_data(od4), .triggered(trg4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            st[k] = 0; pulses[k] = 0; prv[k] = 0; tmo[k] = 0; idx[k] = 0;
            for (int j = 0; j < NC; j++) mb[k][j] = 0;
        end
    endfunction

    function automatic void model_edge(input int k);
        int  d, s, tl;
        bit  kept;
        d = (k == 1) ? 4 : 1;
        s = int'(sample);
        tl = int'(trig_level);
        if (freeze) return;
        kept = 1'b0;
        if (sample_valid) begin
            kept = (pulses[k] % d) == 0;
            pulses[k]++;
        end
        case (st[k])
            0: if (kept) begin
                if ((prv[k] < tl && s >= tl) || tmo[k] == AUTO) begin
                    mb[k][0] = s; idx[k] = 1; st[k] = 1; tmo[k] = 0;
                end else tmo[k]++;
            end
            1: if (kept) begin
                mb[k][idx[k]] = s;
                if (idx[k] == NC - 1) st[k] = 2; else idx[k]++;
            end
            default: st[k] = 0;
        endcase
        if (kept) prv[k] = s;
    endfunction

    function automatic logic [15:0] exp_pix(input int k, input int px, input int py, input int md);
        int h, ym, dh, dy, m;
        bit lit, base;
        if (px >= NC || py >= NR) return 16'h0000;
        h = mb[k][px] / 64;
        ym = NR - 1 - py;
        if (md == 0) begin
            lit = ym < h; m = h; base = (h == 0) && (ym == 0);
        end else begin
            dh = (h >= 32) ? h - 32 : 32 - h;
            dy = (ym >= 32) ? ym - 32 : 32 - ym;
            lit = dy < dh; m = 2 * dh; base = (h == 32) && (ym == 32);
        end
        if (lit) begin
            if (3 * m < NR) return 16'h867F;
            if (3 * m < 2 * NR) return 16'hFD8F;
            return 16'hF81F;
        end
        if (base) return 16'hFFFF;
`ifdef WAVE_SCOPE_GRID_EN
        if (px % 16 == 0 || py % 16 == 0) return 16'h2104;
`endif
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else begin model_edge(0); model_edge(1); end
        #1;
    endtask

    task automatic chk_trg();
        chk("trg1", 32'(trg1), 32'(st[0] != 0));
        chk("trg4", 32'(trg4), 32'(st[1] != 0));
    endtask

    task automatic check_buf(input int k);
        for (int j = 0; j < NC; j++) begin
            if (k == 0) chk("buf1", 32'(dut1.hgt_buf[j]), 32'(mb[0][j] / 64));
            else        chk("buf4", 32'(dut4.hgt_buf[j]), 32'(mb[1][j] / 64));
        end
    endtask

    task automatic pix_check(input int n);
        int px, py, md;
        for (int i = 0; i < n; i++) begin
            px = $urandom_range(0, 103);
            py = $urandom_range(0, 69);
            md = $urandom_range(0, 1);
            x = 7'(px); y = 7'(py); mode = md[0];
            tick();
            chk("pix1", 32'(od1), 32'(exp_pix(0, px, py, md)));
            chk("pix4", 32'(od4), 32'(exp_pix(1, px, py, md)));
        end
    endtask

    task automatic do_reset();
        sample_valid = 1'b0; freeze = 1'b0; rst = 1'b1;
        model_reset();
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        #3;
        do_reset();
        chk("rst_od1", 32'(od1), 0);
        chk("rst_od4", 32'(od4), 0);
        chk("rst_trg1", 32'(trg1), 0);
        chk("rst_idx", 32'(dut1.wr_idx), 0);
        check_buf(0);
        x = 7'd0; y = 7'd63; mode = 1'b0;
        tick();
        chk("rst_baseline", 32'(od1), 32'h0000FFFF);

        // ramp step 64, trigger at 2048
        trig_level = 12'd2048; sample_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            sample = 12'((i * 64) % 4096);
            tick();
            chk_trg();
            if (i == 31) chk("pre_trig", 32'(trg1), 0);
            if (i == 32) chk("trig_2048", 32'(trg1), 1);
        end
        sample_valid = 1'b0;
        tick();
        chk("e0", 32'(dut1.hgt_buf[0]), 32);
        chk("e95", 32'(dut1.hgt_buf[95]), 4032 / 64);
        chk("hold_to_arm", 32'(trg1), 0);
        check_buf(0);
        pix_check(400);
        sample_valid = 1'b1;
        for (int i = 128; i < 420; i++) begin
            sample = 12'((i * 64) % 4096);
            tick();
            chk_trg();
        end
        sample_valid = 1'b0;
        tick();
        check_buf(0); check_buf(1);
        for (int j = 0; j < NC - 1; j++)
            chk("d4_step", 32'((dut4.hgt_buf[j+1] - dut4.hgt_buf[j]) & 6'h3F), 4);

        // constant 100: forced trigger on the 256th kept sample
        do_reset();
        trig_level = 12'd2048; sample = 12'd100; sample_valid = 1'b1;
        for (int i = 1; i <= 256 + 95; i++) begin
            tick();
            chk_trg();
            if (i == 255) chk("auto_pre", 32'(trg1), 0);
            if (i == 256) chk("auto_fire", 32'(trg1), 1);
        end
        sample_valid = 1'b0;
        tick();
        for (int j = 0; j < NC; j++) chk("all100", 32'(dut1.hgt_buf[j]), 100 / 64);

        // DECIM 4, ramp step 1
        do_reset();
        trig_level = 12'd2048; sample_valid = 1'b1;
        for (int i = 2000; i < 2440; i++) begin
            sample = 12'(i);
            tick();
            chk_trg();
            if (st[1] == 1) chk("idx4", 32'(dut4.wr_idx), 32'(idx[1]));
        end
        sample_valid = 1'b0;
        tick();
        check_buf(1);

        // freeze beats a simultaneous trigger
        do_reset();
        trig_level = 12'd2048; sample = 12'd3000; sample_valid = 1'b1; freeze = 1'b1;
        tick();
        chk("frz_no_trig", 32'(trg1), 0);
        freeze = 1'b0;
        tick();
        chk("unfrz_trig", 32'(trg1), 1);

        // freeze mid-FILL, then in HOLD
        do_reset();
        trig_level = 12'd2048; sample_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin sample = 12'((i * 64) % 4096); tick(); end
        freeze = 1'b1;
        for (int c = 0; c < 50; c++) begin
            sample_valid = 1'($urandom_range(0, 1));
            sample = 12'($urandom);
            tick();
            chk("frz_idx", 32'(dut1.wr_idx), 32'(idx[0]));
            chk_trg();
        end
        chk("frz_idx28", 32'(dut1.wr_idx), 28);
        check_buf(0); check_buf(1);
        freeze = 1'b0; sample_valid = 1'b1;
        for (int i = 60; i < 128; i++) begin sample = 12'((i * 64) % 4096); tick(); chk_trg(); end
        freeze = 1'b1;
        for (int c = 0; c < 20; c++) begin tick(); chk("hold_frz", 32'(trg1), 1); end
        freeze = 1'b0; sample_valid = 1'b0;
        tick();
        chk("hold_rel", 32'(trg1), 0);
        check_buf(0); check_buf(1);

        // async reset mid-FILL
        do_reset();
        trig_level = 12'd2048; sample_valid = 1'b1;
        x = 7'd0; y = 7'd63; mode = 1'b0;
        for (int i = 0; i < 40; i++) begin sample = 12'((i * 64) % 4096); tick(); end
        chk("pre_arst", 32'(od1), 32'h0000FD8F);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_od1", 32'(od1), 0);
        chk("arst_od4", 32'(od4), 0);
        chk("arst_trg1", 32'(trg1), 0);
        chk("arst_trg4", 32'(trg4), 0);
        chk("arst_idx", 32'(dut1.wr_idx), 0);
        model_reset();
        tick();
        rst = 1'b0;
        sample = 12'd3000; sample_valid = 1'b1;
        tick();
        chk("phase0_trg4", 32'(trg4), 1);
        chk_trg();

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 256 == 0) trig_level = 12'($urandom);
            sample_valid = 1'($urandom_range(0, 1));
            sample = 12'($urandom);
            freeze = ($urandom_range(0, 9) == 0);
            tick();
            chk_trg();
            if (c % 500 == 499) begin
                sample_valid = 1'b0; freeze = 1'b0;
                check_buf(0); check_buf(1);
                pix_check(50);
            end
        end

        // directed pixel mapping
        do_reset();
        trig_level = 12'd1; sample_valid = 1'b1;
        for (int j = 0; j < NC; j++) begin
            sample = (j == 0) ? 12'd2048 : (j == 10) ? 12'd2560 : 12'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        tick();
        x = 7'd10; y = 7'd24; mode = 1'b0;
        tick();
        chk("m0_lit", 32'(od1), 32'h0000FD8F);
        y = 7'd23;
        #1;
        chk("latency_hold", 32'(od1), 32'h0000FD8F);
        tick();
        chk("m0_dark", 32'(od1), 0);
        x = 7'd0; y = 7'd31; mode = 1'b1;
        tick();
        chk("m1_base", 32'(od1), 32'h0000FFFF);
        x = 7'd100; y = 7'd10;
        tick();
        chk("x_oob", 32'(od1), 0);
        pix_check(800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
